// File: rtl/pkg_tamagotchi.sv
// Shared constants for the OLED datapath: pet-state encodings, animation lengths,
// frame geometry and the frame sequencer state encoding.
package pkg_tamagotchi;

  localparam logic [3:0] EST_IDLE       = 4'b0000;
  localparam logic [3:0] EST_DORMINDO   = 4'b0001;
  localparam logic [3:0] EST_COMENDO    = 4'b0010;
  localparam logic [3:0] EST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] EST_MORTO      = 4'b1000;

  localparam int NUM_BYTES_DEF = 1024;
  localparam int ANIM_DIV_DEF  = 4;
  localparam int BC_W          = 10;
  localparam int GAP_W         = 17;

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    BUSCA   = 3'd1,
    CAPTURA = 3'd2,
    ENVIA   = 3'd3,
    FIM     = 3'd4
  } seq_state_t;

  // Anything that is not a known one-hot state animates like IDLE.
  function automatic logic [3:0] anim_len(input logic [3:0] est);
    case (est)
      EST_DORMINDO:   anim_len = 4'd4;
      EST_COMENDO:    anim_len = 4'd5;
      EST_DANDO_AULA: anim_len = 4'd7;
      EST_MORTO:      anim_len = 4'd8;
      default:        anim_len = 4'd6;
    endcase
  endfunction

endpackage

// File: rtl/contador_animacao.sv
// Animation stepper: counts completed frames and advances anim_idx every ANIM_DIV
// frames, wrapping at the length of the latched pet state.
module contador_animacao
  import pkg_tamagotchi::*;
#(
  parameter int ANIM_DIV = ANIM_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_done,
  input  logic [3:0] est_q,
  input  logic       est_changed,
  output logic [2:0] anim_idx
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CW-1:0] frame_cnt;
  logic [3:0]    len;
  logic          step;

  assign len  = anim_len(est_q);
  assign step = frame_done && (frame_cnt == CW'(ANIM_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      anim_idx  <= '0;
    end else if (est_changed) begin
      // A new pet state always starts its animation from the first image.
      frame_cnt <= '0;
      anim_idx  <= '0;
    end else if (frame_done) begin
      if (step) begin
        frame_cnt <= '0;
        anim_idx  <= ({1'b0, anim_idx} >= (len - 4'd1)) ? 3'd0 : anim_idx + 3'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sequenciador_frames.sv
// OLED frame scheduler: walks byte_counter through the image controller and streams
// each byte over valid/ready. Optional start pacing with SEQ_FRAME_PACING_EN.
module sequenciador_frames
  import pkg_tamagotchi::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int ANIM_DIV  = ANIM_DIV_DEF
`ifdef SEQ_FRAME_PACING_EN
  ,
  parameter int FRAME_GAP = 50000
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            display_ready,
  input  logic [3:0]      estado,
  input  logic [7:0]      data_in,
  input  logic            tx_ready,
  output logic [BC_W-1:0] byte_counter,
  output logic [2:0]      anim_idx,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            frame_done,
  output logic            busy
);

  seq_state_t state, state_nxt;
  logic       start, last_byte, gap_ok, est_changed, fim;
  logic [3:0] est_q;

  assign start       = (state == ESPERA) && display_ready && gap_ok;
  assign last_byte   = (byte_counter == BC_W'(NUM_BYTES - 1));
  assign est_changed = start && (estado != est_q);
  assign fim         = (state == FIM);

`ifdef SEQ_FRAME_PACING_EN
  logic [GAP_W-1:0] gap_cnt;

  // Resets saturated so the first frame after reset is not held back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              gap_cnt <= GAP_W'(FRAME_GAP);
    else if (start)                          gap_cnt <= '0;
    else if (gap_cnt < GAP_W'(FRAME_GAP))    gap_cnt <= gap_cnt + 1'b1;
  end

  assign gap_ok = (gap_cnt >= GAP_W'(FRAME_GAP - 1));
`else
  assign gap_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ESPERA;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ESPERA:  if (start) state_nxt = BUSCA;
      BUSCA:   state_nxt = CAPTURA;
      CAPTURA: state_nxt = ENVIA;
      ENVIA:   if (tx_ready) state_nxt = last_byte ? FIM : BUSCA;
      FIM:     state_nxt = ESPERA;
      default: state_nxt = ESPERA;
    endcase
  end

  // Byte datapath; estado is only sampled at frame start so a frame never mixes images.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_counter <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      est_q        <= EST_IDLE;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ESPERA: if (start) begin
          busy         <= 1'b1;
          byte_counter <= '0;
          est_q        <= estado;
        end
        CAPTURA: begin
          tx_data  <= data_in;
          tx_valid <= 1'b1;
        end
        ENVIA: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (!last_byte) byte_counter <= byte_counter + 1'b1;
        end
        FIM: begin
          frame_done   <= 1'b1;
          busy         <= 1'b0;
          byte_counter <= '0;
        end
        default: ;
      endcase
    end
  end

  contador_animacao #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_done  (fim),
    .est_q       (est_q),
    .est_changed (est_changed),
    .anim_idx    (anim_idx)
  );

endmodule

// File: tb/tb_sequenciador_frames.sv
// Directed bench for sequenciador_frames: two instances share timing, one held in
// DORMINDO for the wrap sequence, the other switching IDLE->MORTO mid-frame.
module tb_sequenciador_frames;
  import pkg_tamagotchi::*;

  logic       clk = 1'b0;
  logic       rst_n, display_ready, tx_ready;
  logic [3:0] est_a, est_b;
  logic [7:0] dat_a, dat_b;

  logic [9:0] bc_a, bc_b;
  logic [2:0] anim_a, anim_b;
  logic [7:0] txd_a, txd_b;
  logic       txv_a, txv_b, fd_a, fd_b, busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_start = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Image controller model: registered read returning the low address byte.
  always @(posedge clk) begin
    dat_a <= bc_a[7:0];
    dat_b <= bc_b[7:0];
  end

  sequenciador_frames #(
    .NUM_BYTES (1024),
    .ANIM_DIV  (4)
`ifdef SEQ_FRAME_PACING_EN
    , .FRAME_GAP (4000)
`endif
  ) u_a (
    .clk (clk), .rst_n (rst_n), .display_ready (display_ready), .estado (est_a),
    .data_in (dat_a), .tx_ready (tx_ready), .byte_counter (bc_a), .anim_idx (anim_a),
    .tx_data (txd_a), .tx_valid (txv_a), .frame_done (fd_a), .busy (busy_a)
  );

  sequenciador_frames #(
    .NUM_BYTES (1024),
    .ANIM_DIV  (4)
`ifdef SEQ_FRAME_PACING_EN
    , .FRAME_GAP (4000)
`endif
  ) u_b (
    .clk (clk), .rst_n (rst_n), .display_ready (display_ready), .estado (est_b),
    .data_in (dat_b), .tx_ready (tx_ready), .byte_counter (bc_b), .anim_idx (anim_b),
    .tx_data (txd_b), .tx_valid (txv_b), .frame_done (fd_b), .busy (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_anim_a(input int f);
    return (f / 4) % 4;
  endfunction

  function automatic int exp_anim_b(input int f);
    return (f <= 9) ? (f / 4) % 6 : ((f - 9) / 4) % 8;
  endfunction

  function automatic int exp_spacing(input int f);
`ifdef SEQ_FRAME_PACING_EN
    return (f > 0) ? 4000 : 0;
`else
    return (f == 3) ? 3079 : 3074;
`endif
  endfunction

  task automatic run_frame(input int f, input int stall_at, input int switch_at, input int drop_at);
    int nxt, oerr, serr, bud, stall_left, t0;
    nxt = 0; oerr = 0; serr = 0; bud = 0;
    stall_left = (stall_at >= 0) ? 5 : 0;
    while (!busy_a && bud < 10000) begin @(posedge clk); #1; bud++; end
    check("frame_start", 32'(busy_a & ~fd_a), 32'd1);
    t0 = cyc;
    if (last_start >= 0) check("start_spacing", t0 - last_start, exp_spacing(f));
    last_start = t0;
    if (f == 10) begin
      check("b_est_q_new", 32'(u_b.est_q), 32'(EST_MORTO));
      check("b_anim_clear", 32'(anim_b), 32'd0);
    end
    bud = 0;
    while (!fd_a && bud < 4000) begin
      tx_ready = 1'b1;
      if (txv_a) begin
        if (nxt == stall_at && stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
          if (txd_a !== 8'(stall_at) || bc_a !== 10'(stall_at)) serr++;
        end else begin
          if (txd_a !== nxt[7:0] || bc_a !== nxt[9:0]) oerr++;
          nxt++;
        end
      end
      if (txv_b !== txv_a || txd_b !== txd_a) oerr++;
      if (nxt == switch_at) est_b = EST_MORTO;
      if (nxt == drop_at) display_ready = 1'b0;
      @(posedge clk); #1; bud++;
    end
    check("frame_done", 32'(fd_a), 32'd1);
    check("xfer_count", nxt, 1024);
    check("xfer_order", oerr, 0);
    check("frame_cycles", cyc - t0, 3073 + ((stall_at >= 0) ? 5 : 0));
    check("busy_drop", 32'(busy_a), 32'd0);
    if (stall_at >= 0) begin
      check("stall_hold", serr, 0);
      check("stall_len", stall_left, 0);
    end
    check("anim_a", 32'(anim_a), exp_anim_a(f));
    check("anim_b", 32'(anim_b), exp_anim_b(f));
    if (f == 9) check("b_est_q_kept", 32'(u_b.est_q), 32'(EST_IDLE));
  endtask

  initial begin
    int bud, qerr;
    rst_n = 1'b0; display_ready = 1'b0; tx_ready = 1'b1;
    est_a = EST_DORMINDO; est_b = EST_IDLE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_txv", 32'(txv_a), 32'd0);
    check("rst_bc", 32'(bc_a), 32'd0);
    rst_n = 1'b1;
    qerr = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy_a || txv_a || fd_a || bc_a != 0 || txd_a != 0 || anim_a != 0) qerr++;
    end
    check("idle_quiet", qerr, 0);
    check("idle_anim", 32'(anim_a), 32'd0);

    display_ready = 1'b1;
    for (int f = 1; f <= 16; f++)
      run_frame(f, (f == 2) ? 37 : -1, (f == 9) ? 500 : -1, (f == 16) ? 100 : -1);

    // display_ready is low: no new frame may start.
    qerr = 0;
    @(posedge clk); #1;
    repeat (10) begin
      if (busy_a || txv_a || fd_a) qerr++;
      @(posedge clk); #1;
    end
    check("ready_gate", qerr, 0);

    // Reset in the middle of a frame.
    display_ready = 1'b1;
    bud = 0;
    while (!(txv_a && bc_a == 10'd700) && bud < 5000) begin
      tx_ready = 1'b1;
      @(posedge clk); #1; bud++;
    end
    check("abort_reach", 32'(bc_a), 32'd700);
    rst_n = 1'b0;
    #1;
    check("abort_txv", 32'(txv_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_bc", 32'(bc_a), 32'd0);
    check("abort_anim_b", 32'(anim_b), 32'd0);
    @(posedge clk); #1;
    check("abort_txv_next", 32'(txv_a), 32'd0);
    rst_n = 1'b1;
    bud = 0;
    while (!txv_a && bud < 50) begin @(posedge clk); #1; bud++; end
    check("restart_txv", 32'(txv_a), 32'd1);
    check("restart_bc", 32'(bc_a), 32'd0);
    check("restart_busy", 32'(busy_a), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
